// File: rtl/mux_scan.sv
// mux_scan: registered N:1 channel multiplexer with manual and auto-scan modes.
//
// Optional feature: define MUX_SCAN_MASK_EN to add the ch_mask port. Scan
// steps then skip channels whose mask bit is 0. Manual mode ignores the mask.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   din      in   packed channel data, channel k = din[k*W +: W]
//   sel      in   manual channel select
//   scan     in   1 = auto-scan, 0 = manual
//   hold     in   scan mode: freeze dwell counter and channel
//   ch_mask  in   channel enable mask (MUX_SCAN_MASK_EN only)
//   y        out  registered selected data
//   ch       out  registered index of the channel driving y
//   step     out  pulse on the cycle ch advances in scan mode
//   wrap     out  pulse when a scan step passes the last channel
//   sel_err  out  pulse when manual sel >= CH
//
// state  | meaning
// MANUAL | ch follows sel, dwell counter held at 0
// SCAN   | ch advances every DWELL un-held cycles
module mux_scan #(
    parameter int CH    = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    parameter int SELW  = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] din,
    input  logic [SELW-1:0] sel,
    input  logic            scan,
    input  logic            hold,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CH-1:0]   ch_mask,
`endif
    output logic [W-1:0]    y,
    output logic [SELW-1:0] ch,
    output logic            step,
    output logic            wrap,
    output logic            sel_err
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW:0]   CH_LIM   = (SELW + 1)'(CH);

    typedef enum logic {MANUAL, SCAN} mode_t;

    mode_t           mode, mode_nxt;
    logic [CW-1:0]   cnt, cnt_cur, cnt_nxt;
    logic [SELW-1:0] ch_nxt, adv_ch;
    logic            adv_any, adv_wrap;
    logic            step_nxt, wrap_nxt, err_nxt;
    logic [W-1:0]    y_nxt;
`ifdef MUX_SCAN_MASK_EN
    int              cand;
`endif

    // Channel that the next scan step would land on.
    always_comb begin
        adv_ch   = ch;
        adv_wrap = 1'b0;
        adv_any  = 1'b1;
`ifdef MUX_SCAN_MASK_EN
        adv_any  = 1'b0;
        cand     = 0;
        // Search forward from ch+1, wrapping; landing at or below ch
        // means index CH-1 was passed (this includes landing on ch itself).
        for (int i = 1; i <= CH; i++) begin
            cand = (int'(ch) + i) % CH;
            if (!adv_any && ch_mask[cand]) begin
                adv_any  = 1'b1;
                adv_ch   = SELW'(cand);
                adv_wrap = (cand <= int'(ch));
            end
        end
`else
        if (int'(ch) == CH - 1) begin
            adv_ch   = '0;
            adv_wrap = 1'b1;
        end else begin
            adv_ch   = ch + 1'b1;
        end
`endif
    end

    always_comb begin
        mode_nxt = mode;
        cnt_nxt  = cnt;
        ch_nxt   = ch;
        step_nxt = 1'b0;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        // Entering scan always starts a fresh dwell.
        cnt_cur  = (mode == SCAN) ? cnt : '0;

        if (!scan) begin
            mode_nxt = MANUAL;
            cnt_nxt  = '0;
            if ({1'b0, sel} >= CH_LIM) begin
                err_nxt = 1'b1;
            end else begin
                ch_nxt  = sel;
            end
        end else begin
            mode_nxt = SCAN;
            cnt_nxt  = cnt_cur;
            if (!hold) begin
                if (cnt_cur == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (adv_any) begin
                        ch_nxt   = adv_ch;
                        step_nxt = 1'b1;
                        wrap_nxt = adv_wrap;
                    end
                end else begin
                    cnt_nxt = cnt_cur + 1'b1;
                end
            end
        end

        // y is sampled from the channel ch takes on this same edge.
        y_nxt = din[int'(ch_nxt) * W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode    <= MANUAL;
            cnt     <= '0;
            ch      <= '0;
            y       <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            mode    <= mode_nxt;
            cnt     <= cnt_nxt;
            ch      <= ch_nxt;
            y       <= y_nxt;
            step    <= step_nxt;
            wrap    <= wrap_nxt;
            sel_err <= err_nxt;
        end
    end

endmodule
